// File: rtl/csat_sweep_pkg.sv
// Shared types and limits for the CSAT exhaustive-sweep controller.
package csat_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_ORACLE_LAT = 7;

endpackage

// File: rtl/csat_delay_line.sv
// Valid/data shift register that realigns issued candidates with the oracle's late sat result.
module csat_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         any_vld
);

  if (DEPTH == 0) begin : g_wire
    assign out_vld  = in_vld;
    assign out_data = in_data;
    assign any_vld  = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0] vld_sr;
    logic [W-1:0]     data_sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_sr <= '0;
      end else if (flush) begin
        vld_sr <= '0;
      end else begin
        vld_sr[0] <= in_vld;
        for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
      end
    end

    // Data only matters while its valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
      data_sr[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) data_sr[i] <= data_sr[i-1];
    end

    assign out_vld  = vld_sr[DEPTH-1];
    assign out_data = data_sr[DEPTH-1];
    assign any_vld  = |vld_sr;
  end

endmodule

// File: rtl/csat_sweep_controller.sv
// Exhaustive-sweep sequencer for a combinational CSAT oracle: issues one candidate per
// cycle, realigns sat through a delay line, stops on the first hit and can resume past it.
module csat_sweep_controller
  import csat_sweep_pkg::*;
#(
  parameter int N_VARS     = 13,
  parameter int ORACLE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              next,
  input  logic              abort,
  output logic [N_VARS-1:0] assign_out,
  input  logic              sat_in,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [N_VARS-1:0] solution,
  output logic [N_VARS:0]   evaluated
);

  // Latencies beyond the supported range are clamped to the longest line.
  localparam int LAT = (ORACLE_LAT > MAX_ORACLE_LAT) ? MAX_ORACLE_LAT : ORACLE_LAT;
  localparam logic [N_VARS-1:0] ALL_ONES = '1;
  localparam logic [N_VARS:0]   SPACE    = {1'b1, {N_VARS{1'b0}}};

  state_t            state, state_nxt;
  logic [N_VARS-1:0] cand;
  logic              vld_p0;
  logic              tail_vld_p1;
  logic [N_VARS-1:0] tail_cand_p1;
  logic              line_busy;
  logic              active, hit, drained, flush;

  assign active  = (state == SWEEP) || (state == DRAIN);
  assign hit     = active && tail_vld_p1 && sat_in && !abort;
  assign drained = (state == DRAIN) && !vld_p0 && !line_busy;
  assign flush   = abort || hit;

  // Stage p0 is the issue register on assign_out; the line adds LAT stages up to the tail p1.
  csat_delay_line #(
    .W     (N_VARS),
    .DEPTH (LAT)
  ) u_line (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_vld   (vld_p0),
    .in_data  (assign_out),
    .out_vld  (tail_vld_p1),
    .out_data (tail_cand_p1),
    .any_vld  (line_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) state_nxt = SWEEP;
        SWEEP: if (hit) state_nxt = DONE;
               else if (cand == ALL_ONES) state_nxt = DRAIN;
        DRAIN: if (hit || drained) state_nxt = DONE;
        DONE:  if (start) state_nxt = SWEEP;
               else if (next && found && solution != ALL_ONES) state_nxt = SWEEP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = active;
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      assign_out <= '0;
      vld_p0     <= 1'b0;
      cand       <= '0;
      found      <= 1'b0;
      solution   <= '0;
      evaluated  <= '0;
    end else if (abort) begin
      assign_out <= '0;
      vld_p0     <= 1'b0;
      found      <= 1'b0;
      solution   <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        IDLE: begin
          assign_out <= '0;
          if (start) begin
            cand      <= '0;
            evaluated <= '0;
          end
        end
        SWEEP, DRAIN: begin
          if (tail_vld_p1) evaluated <= evaluated + 1'b1;
          if (hit) begin
            found    <= 1'b1;
            solution <= tail_cand_p1;
          end else if (state == SWEEP) begin
            assign_out <= cand;
            vld_p0     <= 1'b1;
            cand       <= cand + 1'b1;
          end else if (drained) begin
            found     <= 1'b0;
            evaluated <= SPACE;
          end
        end
        DONE: begin
          if (start) begin
            cand      <= '0;
            evaluated <= '0;
            found     <= 1'b0;
          end else if (next && found) begin
            // Resuming past the last candidate leaves nothing to search: report exhaustion.
            found <= 1'b0;
            cand  <= solution + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
